// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// reset PC and instruction-buffer entry layout {inst[63:32], pc[31:0]}.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } fetchState_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          ENTRY_W          = 64;

   function automatic logic [31:0] nextPc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with push, pop, flush and occupancy count.
// Storage is not reset; only pointers and count are.
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] pushData,
   output logic [WIDTH-1:0] headData,
   output logic [CNT_W-1:0] count,
   output logic             notEmpty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic             doPush, doPop, full;

   function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign notEmpty = (count != '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign doPop    = pop && notEmpty;
   assign doPush   = push && (!full || doPop);
   assign headData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= incPtr(wrPtr);
         if (doPop)  rdPtr <= incPtr(rdPtr);
         if (doPush && !doPop)      count <= count + CNT_W'(1);
         else if (!doPush && doPop) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: request FSM in front of a small instruction buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc4,
   output logic        fetch_fault
);

   localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   fetchState_t          state, stateNext;
   logic [31:0]          fetchPc, fetchPcNext, discardAddr, targetPc;
   logic                 push, pop, flush, bufValid, enterDiscard, misaligned;
   logic [ENTRY_W-1:0]   headData;
   logic [CNT_W-1:0]     count;
   logic [CNT_W:0]       countAfter;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic faultReg;

   assign misaligned  = redirect && (redirect_pc[1:0] != 2'b00);
   assign targetPc    = redirect_pc;
   assign fetch_fault = faultReg;

   always_ff @(posedge clk) begin
      if (reset)                           faultReg <= 1'b0;
      else if (misaligned && state != HALT) faultReg <= 1'b1;
   end
`else
   assign misaligned  = 1'b0;
   assign targetPc    = redirect_pc & ~32'h3;
   assign fetch_fault = 1'b0;
`endif

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .pushData ({imem_rdata, fetchPc}),
      .headData (headData),
      .count    (count),
      .notEmpty (bufValid)
   );

   assign pop        = bufValid && inst_ready;
   assign countAfter = {1'b0, count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

   always_comb begin
      stateNext    = state;
      fetchPcNext  = fetchPc;
      push         = 1'b0;
      flush        = 1'b0;
      enterDiscard = 1'b0;
      if (misaligned && state != HALT) begin
         flush     = 1'b1;
         stateNext = HALT;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  flush       = 1'b1;
                  fetchPcNext = targetPc;
               end else if ({1'b0, count} < DEPTH_C) begin
                  stateNext = REQ;
               end
            end
            REQ: begin
               if (redirect) begin
                  flush       = 1'b1;
                  fetchPcNext = targetPc;
                  if (imem_ack) begin
                     stateNext = IDLE;
                  end else begin
                     stateNext    = DISCARD;
                     enterDiscard = 1'b1;
                  end
               end else if (imem_ack) begin
                  push        = 1'b1;
                  fetchPcNext = nextPc(fetchPc);
                  if (countAfter >= DEPTH_C) stateNext = IDLE;
               end
            end
            DISCARD: begin
               // The outstanding request keeps its address; only the target moves.
               if (redirect) fetchPcNext = targetPc;
               if (imem_ack) stateNext = IDLE;
            end
            HALT: begin
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         fetchPc <= RESET_PC;
      end else begin
         state   <= stateNext;
         fetchPc <= fetchPcNext;
      end
   end

   always_ff @(posedge clk) begin
      if (enterDiscard) discardAddr <= fetchPc;
   end

   assign imem_req   = (state == REQ) || (state == DISCARD);
   assign imem_addr  = (state == DISCARD) ? discardAddr : fetchPc;
   assign inst_valid = bufValid;
   assign inst       = bufValid ? headData[ENTRY_W-1:32] : 32'h0;
   assign inst_pc    = bufValid ? headData[31:0] : 32'h0;
   assign inst_pc4   = bufValid ? nextPc(headData[31:0]) : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table, then randomized
// traffic checked against a queue-based reference model.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst, inst_pc, inst_pc4;
   logic        fetch_fault;

   int tests = 0;
   int fails = 0;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_pc4    (inst_pc4),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ack;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        ready, chk, eReq;
      logic [31:0] eAddr;
      logic        eValid;
      logic [31:0] eInst, ePc;
      logic        eFault;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, ack, input logic [31:0] rdata, input logic redir,
                      input logic [31:0] rpc, input logic ready, chk, eReq,
                      input logic [31:0] eAddr, input logic eValid,
                      input logic [31:0] eInst, ePc, input logic eFault);
      vec_t v;
      v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
      v.ready = ready; v.chk = chk; v.eReq = eReq; v.eAddr = eAddr;
      v.eValid = eValid; v.eInst = eInst; v.ePc = ePc; v.eFault = eFault;
      vecs.push_back(v);
   endtask

   // First row lets the reset edge land; second row checks the reset state.
   task automatic rst2();
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutputs(input logic eReq, input logic [31:0] eAddr, input logic eValid,
                               input logic [31:0] eInst, ePc, input logic eFault);
      check("imem_req",    {31'b0, imem_req},    {31'b0, eReq});
      check("imem_addr",   imem_addr,            eAddr);
      check("inst_valid",  {31'b0, inst_valid},  {31'b0, eValid});
      check("inst",        inst,                 eValid ? eInst : 32'h0);
      check("inst_pc",     inst_pc,              eValid ? ePc : 32'h0);
      check("inst_pc4",    inst_pc4,             eValid ? ePc + 32'd4 : 32'h0);
      check("fetch_fault", {31'b0, fetch_fault}, {31'b0, eFault});
   endtask

   // Reference model state
   logic [63:0] q[$];
   logic        mBusy, mDrop, mHalt, mFault;
   logic [31:0] mPc, mReqAddr;

   task automatic modelStep(input logic ack, input logic [31:0] rdata, input logic redir,
                            input logic [31:0] rpc, input logic ready);
      logic        popNow, mis;
      logic [31:0] tgt;
      popNow = (q.size() != 0) && ready;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis = redir && (rpc[1:0] != 2'b00);
      tgt = rpc;
`else
      mis = 1'b0;
      tgt = {rpc[31:2], 2'b00};
`endif
      if (mHalt) begin
      end else if (mis) begin
         q.delete(); mHalt = 1; mFault = 1; mBusy = 0; mDrop = 0;
      end else if (mBusy && mDrop) begin
         if (redir) mPc = tgt;
         if (ack) begin mBusy = 0; mDrop = 0; end
      end else if (mBusy) begin
         if (redir) begin
            q.delete(); mPc = tgt;
            if (ack) mBusy = 0; else mDrop = 1;
         end else begin
            if (popNow) void'(q.pop_front());
            if (ack) begin
               q.push_back({rdata, mReqAddr});
               mPc = mReqAddr + 32'd4;
               mReqAddr = mPc;
               mBusy = (q.size() < DEPTH);
            end
         end
      end else begin
         if (redir) begin
            q.delete(); mPc = tgt;
         end else begin
            if (q.size() < DEPTH) begin mBusy = 1; mReqAddr = mPc; end
            if (popNow) void'(q.pop_front());
         end
      end
   endtask

   initial begin
      reset = 1; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; inst_ready = 1;
      repeat (2) @(posedge clk);

      // Streaming fetch, zero-wait memory
      rst2();
      add(0, 0, 0,            0, 0, 1, 1, 0, 32'h0,  0, 0,            0,     0);
      add(0, 1, 32'hA000_0000, 0, 0, 1, 1, 1, 32'h0,  0, 0,            0,     0);
      add(0, 1, 32'hA000_0001, 0, 0, 1, 1, 1, 32'h4,  1, 32'hA000_0000, 32'h0, 0);
      add(0, 1, 32'hA000_0002, 0, 0, 1, 1, 1, 32'h8,  1, 32'hA000_0001, 32'h4, 0);
      add(0, 1, 32'hA000_0003, 0, 0, 1, 1, 1, 32'hC,  1, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0,            0, 0, 1, 1, 1, 32'h10, 1, 32'hA000_0003, 32'hC, 0);
      add(0, 0, 0,            0, 0, 1, 1, 1, 32'h10, 0, 0,            0,     0);
      // Backpressure fills the buffer, one pop re-issues at 8
      rst2();
      add(0, 0, 0,            0, 0, 0, 1, 0, 32'h0, 0, 0,            0,     0);
      add(0, 1, 32'hB000_0000, 0, 0, 0, 1, 1, 32'h0, 0, 0,            0,     0);
      add(0, 1, 32'hB000_0001, 0, 0, 0, 1, 1, 32'h4, 1, 32'hB000_0000, 32'h0, 0);
      add(0, 0, 0,            0, 0, 1, 1, 0, 32'h8, 1, 32'hB000_0000, 32'h0, 0);
      add(0, 0, 0,            0, 0, 0, 1, 0, 32'h8, 1, 32'hB000_0001, 32'h4, 0);
      add(0, 0, 0,            0, 0, 0, 1, 1, 32'h8, 1, 32'hB000_0001, 32'h4, 0);
      // Redirect while waiting, late ack dropped
      rst2();
      add(0, 0, 0,            0, 0,      1, 1, 0, 32'h0,   0, 0,            0,      0);
      add(0, 0, 0,            1, 32'h100, 1, 1, 1, 32'h0,   0, 0,            0,      0);
      add(0, 0, 0,            0, 0,      1, 1, 1, 32'h0,   0, 0,            0,      0);
      add(0, 0, 0,            0, 0,      1, 1, 1, 32'h0,   0, 0,            0,      0);
      add(0, 1, 32'hDEAD_BEEF, 0, 0,      1, 1, 1, 32'h0,   0, 0,            0,      0);
      add(0, 0, 0,            0, 0,      1, 1, 0, 32'h100, 0, 0,            0,      0);
      add(0, 1, 32'hC000_0000, 0, 0,      1, 1, 1, 32'h100, 0, 0,            0,      0);
      add(0, 0, 0,            0, 0,      1, 1, 1, 32'h104, 1, 32'hC000_0000, 32'h100, 0);
      // Address wrap at the top of memory
      rst2();
      add(0, 0, 0,            1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,         0, 0,            0,             0);
      add(0, 0, 0,            0, 0,            0, 1, 0, 32'hFFFF_FFFC, 0, 0,            0,             0);
      add(0, 1, 32'hD000_0000, 0, 0,            0, 1, 1, 32'hFFFF_FFFC, 0, 0,            0,             0);
      add(0, 0, 0,            0, 0,            0, 1, 1, 32'h0,         1, 32'hD000_0000, 32'hFFFF_FFFC, 0);
      // Reset during an outstanding request; following ack ignored
      rst2();
      add(0, 0, 0,            0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 1, 1, 1, 32'h0, 0, 0, 0, 0);
      add(1, 0, 0,            0, 0, 1, 1, 1, 32'h0, 0, 0, 0, 0);
      add(0, 1, 32'hBAD0_0000, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 1, 1, 1, 32'h0, 0, 0, 0, 0);
      // Misaligned redirect
      rst2();
      add(0, 0, 0, 1, 32'h102, 1, 1, 0, 32'h0, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      add(0, 0, 0, 0, 0,       1, 1, 0, 32'h0, 0, 0, 0, 1);
      add(0, 1, 0, 1, 32'h200, 1, 1, 0, 32'h0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,       1, 1, 0, 32'h0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0,       1, 1, 0, 32'h0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,       1, 1, 0, 32'h0, 0, 0, 0, 0);
`else
      add(0, 0, 0, 0, 0,       1, 1, 0, 32'h100, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0,       1, 1, 1, 32'h100, 0, 0, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         reset = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
         redirect = vecs[i].redir; redirect_pc = vecs[i].rpc; inst_ready = vecs[i].ready;
         @(negedge clk);
         if (vecs[i].chk)
            checkOutputs(vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid,
                         vecs[i].eInst, vecs[i].ePc, vecs[i].eFault);
      end

      // Randomized traffic against the reference model
      @(posedge clk); #1;
      reset = 1; imem_ack = 0; redirect = 0; inst_ready = 0;
      @(posedge clk); #1;
      q.delete(); mBusy = 0; mDrop = 0; mHalt = 0; mFault = 0; mPc = 32'h0; mReqAddr = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         reset      = 0;
         imem_ack   = ($urandom_range(0, 1) == 1);
         imem_rdata = $urandom;
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect   = ($urandom_range(0, 15) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
         redirect_pc = redirect_pc & ~32'h3;
`endif
         @(negedge clk);
         checkOutputs(mBusy, mBusy ? mReqAddr : mPc, q.size() != 0,
                      (q.size() != 0) ? q[0][63:32] : 32'h0,
                      (q.size() != 0) ? q[0][31:0] : 32'h0, mFault);
         modelStep(imem_ack, imem_rdata, redirect, redirect_pc, inst_ready);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries, legal range 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  instruction memory request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1  read data valid this cycle; completes the request.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush the buffer and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port inst_ready  input  1  consumer accepts the head this cycle.
REQ-013 SHALL have port inst  output  32  instruction word at the buffer head.
REQ-014 SHALL have port inst_pc  output  32  address of inst.
REQ-015 SHALL have port inst_pc4  output  32  inst_pc+4, mod 2^32.
REQ-016 SHALL have port fetch_fault  output  1  misaligned redirect (see Configuration); constant 0 when the feature is compiled out.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, DISCARD, HALT; imem_req=1 exactly in REQ and DISCARD.
REQ-018 SHALL hold imem_req and imem_addr stable from assertion until the imem_ack cycle.
REQ-019 IDLE SHALL go to REQ next cycle when count<FIFO_DEPTH and no redirect; imem_addr=fetch_pc.
REQ-020 On imem_ack in REQ: push {imem_rdata, fetch_pc} and set fetch_pc += 4, wrapping 32'hFFFF_FFFC->0.
REQ-021 After the ack, the FSM SHALL stay in REQ when (count+1-pop)<FIFO_DEPTH, else go to IDLE; zero-wait memory yields 1 instruction/cycle.
REQ-022 Pop SHALL occur when inst_valid&&inst_ready; with a zero-latency ack, push-to-inst_valid latency SHALL be 1 cycle.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and both take effect.
REQ-024 Redirect SHALL empty the buffer, set fetch_pc=redirect_pc, and win over any same-cycle push or pop.
REQ-025 Redirect in REQ without ack SHALL enter DISCARD; the old request stays stable and its ack is dropped, then IDLE.
REQ-026 Redirect coincident with imem_ack SHALL drop that data and enter IDLE.
REQ-027 Redirect in DISCARD SHALL update fetch_pc only; the FSM remains in DISCARD.
REQ-028 inst, inst_pc and inst_pc4 SHALL be X-free (zero) whenever inst_valid=0.

Reset
REQ-029 Reset SHALL give: state=IDLE, fetch_pc=RESET_PC, count=0, inst_valid=0, imem_req=0, fetch_fault=0, data outputs=0.
REQ-030 Reset asserted during REQ/DISCARD SHALL abandon the request; an ack arriving the cycle after reset is ignored.
REQ-031 The first imem_req SHALL assert in the second cycle after reset deasserts (IDLE->REQ).

Configuration
REQ-032 With FETCH_MISALIGN_CHECK_EN defined, redirect with redirect_pc[1:0]!=0 SHALL set sticky fetch_fault, flush, and enter HALT, which only reset leaves.
REQ-033 Without FETCH_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0 and fetch_fault tied to 0.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the FSM state encoding, the default RESET_PC, and the buffer entry width (64).
REQ-035 The buffer SHALL be a sub-module fetch_fifo (parameterised depth/width, push/pop/flush, count output).
REQ-036 RTL SHALL total 120-400 lines, with no latches and no combinational path from imem_ack to imem_req.

Verification
REQ-037 Reset, then ack every REQ cycle with inst_ready=1 -> inst_pc sequence 0,4,8,12, one per cycle after the first.
REQ-038 inst_ready=0, FIFO_DEPTH=2 -> exactly 2 pushes, then IDLE with imem_req=0; one pop re-issues at addr 8.
REQ-039 Redirect to 32'h100 while REQ awaits ack, ack 3 cycles later -> data dropped, next imem_addr=32'h100, no stale inst_valid.
REQ-040 fetch_pc=32'hFFFF_FFFC, ack -> inst_pc=32'hFFFF_FFFC, inst_pc4=0, next imem_addr=0.
REQ-041 With FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h102 -> fetch_fault=1, HALT, imem_req=0 until reset; without the macro -> fetch at 32'h100.
